// File: rtl/edge_filter_3x3.sv
// ---------------------------------------------------------------------------
// edge_filter_3x3
//   Streaming 3x3 gradient filter for raster-order grey pixels. For every
//   accepted input pixel at (x,y) it emits exactly one output pixel, which
//   is the result for the 3x3 window centred at (x-1,y-1). The output image
//   is therefore the same size as the input, shifted by one pixel. Window
//   centres that touch the image edge produce 0.
//
//   Modes (iMODE): 0 = |Gx|, 1 = |Gy|, 2 = |Gx|+|Gy|, 3 = aligned passthrough
//   of the window centre. Gradient results saturate to 2^DATA_W-1.
//
//   Pipeline: stage 1 reads the line buffers and shifts the window.
//             stage 2 computes, saturates, masks borders and registers.
//   An input accepted in cycle t produces an oDVAL pulse in cycle t+2.
//   Cycles without iDVAL freeze the counters, line buffers and window.
//
//   Optional feature macro: EDGE_THRESH_EN
//     When defined, port iTHRESH exists and modes 0-2 are binarised:
//     2^DATA_W-1 if the saturated gradient >= iTHRESH, else 0.
//     Mode 3 and border pixels are not affected.
//
// Parameters
//   DATA_W   pixel width, input and output
//   IMG_W    pixels per line (line-buffer depth, X wrap)
//   IMG_H    lines per frame (Y wrap)
//
// Ports
//   clk         in   pixel clock, rising edge
//   rst         in   asynchronous reset, active-high
//   iFRAME_RST  in   synchronous frame restart; next valid pixel is (0,0)
//   iGray       in   input pixel (DATA_W)
//   iDVAL       in   iGray valid, no backpressure
//   iMODE       in   output mode select (2 bits)
//   iTHRESH     in   binarisation threshold (EDGE_THRESH_EN only)
//   oEdge       out  filtered pixel (DATA_W)
//   oDVAL       out  oEdge valid, one pulse per accepted input
// ---------------------------------------------------------------------------
module edge_filter_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iFRAME_RST,
  input  logic [DATA_W-1:0] iGray,
  input  logic              iDVAL,
  input  logic [1:0]        iMODE,
`ifdef EDGE_THRESH_EN
  input  logic [DATA_W-1:0] iTHRESH,
`endif
  output logic [DATA_W-1:0] oEdge,
  output logic              oDVAL
);

  // Gradient working width: a 1-2-1 sum needs DATA_W+2 bits, the signed
  // difference one more, and |Gx|+|Gy| still fits in DATA_W+3 unsigned.
  localparam int SW = DATA_W + 3;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H - 1);
  localparam logic [XW-1:0]     X_TWO    = XW'(2);
  localparam logic [YW-1:0]     Y_TWO    = YW'(2);
  localparam logic [DATA_W-1:0] PIX_MAX  = {DATA_W{1'b1}};
  localparam logic [SW-1:0]     SAT_LIM  = SW'(PIX_MAX);

  // 1-2-1 weighted sum of three pixels, zero-extended to SW bits.
  function automatic logic [SW-1:0] sum121(input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b,
                                           input logic [DATA_W-1:0] c);
    return SW'(a) + (SW'(b) << 1'b1) + SW'(c);
  endfunction

  // Absolute value of a signed gradient as an unsigned magnitude.
  function automatic logic [SW-1:0] mag(input logic signed [SW-1:0] v);
    return v[SW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Clamp a magnitude to the output pixel range.
  function automatic logic [DATA_W-1:0] sat(input logic [SW-1:0] v);
    return (v > SAT_LIM) ? PIX_MAX : v[DATA_W-1:0];
  endfunction

  // Line buffers: lb0 holds row y-1, lb1 holds row y-2 (no reset; the
  // border mask hides whatever they contain at the start of a frame).
  logic [DATA_W-1:0] lb0_mem [0:IMG_W-1];
  logic [DATA_W-1:0] lb1_mem [0:IMG_W-1];

  // Stage 1 state
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] x_cur_s;
  logic [YW-1:0] y_cur_s;
  logic [DATA_W-1:0] lb0_rd_s, lb1_rd_s;
  // win[row][col]: row 2 = current line, col 2 = newest column.
  logic [2:0][2:0][DATA_W-1:0] win_q, win_d;
  logic v1_q, v1_d;
  logic border1_q, border1_d;

  // Stage 2 state
  logic [DATA_W-1:0] edge_q, edge_d;
  logic              dval_q, dval_d;

  // Stage 2 intermediates
  logic signed [SW-1:0] gx_s, gy_s;
  logic [SW-1:0]        mag_s;
  logic [DATA_W-1:0]    sat_s;
  logic [DATA_W-1:0]    grad_pix_s;
  logic [DATA_W-1:0]    filt_s;

  // Stage 1 next state: frame-restart override, counters, window shift, border flag
  always_comb begin
    // A restart coinciding with a valid pixel makes that pixel (0,0).
    x_cur_s   = iFRAME_RST ? '0 : x_q;
    y_cur_s   = iFRAME_RST ? '0 : y_q;
    lb0_rd_s  = lb0_mem[x_cur_s];
    lb1_rd_s  = lb1_mem[x_cur_s];
    x_d       = x_cur_s;
    y_d       = y_cur_s;
    win_d     = win_q;
    v1_d      = iDVAL;
    border1_d = border1_q;
    if (iDVAL) begin
      if (x_cur_s == X_LAST) begin
        x_d = '0;
        y_d = (y_cur_s == Y_LAST) ? '0 : y_cur_s + 1'b1;
      end else begin
        x_d = x_cur_s + 1'b1;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd_s;
      win_d[1][2] = lb0_rd_s;
      win_d[2][2] = iGray;
      // Centre is (x-1,y-1): it touches the top/left edge when x<2 or y<2;
      // the bottom/right edge can never be a centre with this alignment.
      border1_d = (x_cur_s < X_TWO) || (y_cur_s < Y_TWO);
    end else begin
      v1_d = 1'b0;
    end
  end

  // Line-buffer update: the y-1 row value moves down to y-2 as the new pixel lands
  always_ff @(posedge clk) begin
    if (iDVAL) begin
      lb1_mem[x_cur_s] <= lb0_rd_s;
      lb0_mem[x_cur_s] <= iGray;
    end
  end

  // Stage 2 datapath: gradients, mode select, saturation, threshold, border mask
  always_comb begin
    gx_s = $signed(sum121(win_q[0][2], win_q[1][2], win_q[2][2]))
         - $signed(sum121(win_q[0][0], win_q[1][0], win_q[2][0]));
    gy_s = $signed(sum121(win_q[2][0], win_q[2][1], win_q[2][2]))
         - $signed(sum121(win_q[0][0], win_q[0][1], win_q[0][2]));
    case (iMODE)
      2'd0:    mag_s = mag(gx_s);
      2'd1:    mag_s = mag(gy_s);
      2'd2:    mag_s = mag(gx_s) + mag(gy_s);
      default: mag_s = '0;
    endcase
    sat_s = sat(mag_s);
`ifdef EDGE_THRESH_EN
    grad_pix_s = (sat_s >= iTHRESH) ? PIX_MAX : '0;
`else
    grad_pix_s = sat_s;
`endif
    if (iMODE == 2'd3) begin
      filt_s = win_q[1][1];
    end else begin
      filt_s = grad_pix_s;
    end
    dval_d = v1_q;
    if (!v1_q) begin
      edge_d = edge_q;
    end else if (border1_q) begin
      edge_d = '0;
    end else begin
      edge_d = filt_s;
    end
  end

  // Pipeline registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      win_q     <= '0;
      v1_q      <= 1'b0;
      border1_q <= 1'b1;
      edge_q    <= '0;
      dval_q    <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      win_q     <= win_d;
      v1_q      <= v1_d;
      border1_q <= border1_d;
      edge_q    <= edge_d;
      dval_q    <= dval_d;
    end
  end

  assign oEdge = edge_q;
  assign oDVAL = dval_q;

endmodule

// File: tb/tb_edge_filter_3x3.sv
// ---------------------------------------------------------------------------
// tb_edge_filter_3x3
//   Directed self-checking bench for edge_filter_3x3 at IMG_W=8, IMG_H=6,
//   DATA_W=8. Frames are generated from small pattern rules; expected
//   outputs are the hand-derived results for each pattern and mode.
//   Build with EDGE_THRESH_EN defined to exercise the threshold port.
// ---------------------------------------------------------------------------
module tb_edge_filter_3x3;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
`ifdef EDGE_THRESH_EN
  localparam int THR_DEF = 1;   // keeps 0 -> 0 and 255 -> 255 in modes 0-2
`else
  localparam int THR_DEF = -1;  // no binarisation
`endif

  logic       clk;
  logic       rst;
  logic       iFRAME_RST;
  logic [7:0] iGray;
  logic       iDVAL;
  logic [1:0] iMODE;
  logic [7:0] iTHRESH;
  logic [7:0] oEdge;
  logic       oDVAL;

  int asrt_cnt = 0;
  int fail_cnt = 0;
  int cyc      = 0;
  int lat_c0;
  int got_q[$];
  int in_cyc_q[$];

  edge_filter_3x3 #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .iFRAME_RST (iFRAME_RST),
    .iGray      (iGray),
    .iDVAL      (iDVAL),
    .iMODE      (iMODE),
`ifdef EDGE_THRESH_EN
    .iTHRESH    (iTHRESH),
`endif
    .oEdge      (oEdge),
    .oDVAL      (oDVAL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for the latency check
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    asrt_cnt++;
    if (obs != exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output collector: captures every pulse and checks its latency
  always @(negedge clk) begin
    if (oDVAL) begin
      got_q.push_back(int'(oEdge));
      if (in_cyc_q.size() == 0) begin
        check_val("stray_dval", 1, 0);
      end else begin
        lat_c0 = in_cyc_q.pop_front();
        check_val("latency", cyc - lat_c0, 2);
      end
    end
  end

  // Pattern: 0 flat 100, 1 step 0|200 at col 4, 2 ramp x+8y,
  //          3 rows 0-2 = 0 / rows 3-5 = 40, 4 step 200|0 at col 4
  function automatic int pix(input int pat, input int x, input int y);
    case (pat)
      0:       return 100;
      1:       return (x >= 4) ? 200 : 0;
      2:       return x + 8 * y;
      3:       return (y >= 3) ? 40 : 0;
      4:       return (x >= 4) ? 0 : 200;
      default: return 0;
    endcase
  endfunction

  // Hand-derived expected output for input position (x,y).
  function automatic int expect_px(input int pat, input int mode, input int thr,
                                   input int x, input int y);
    int cx, cy, v;
    cx = x - 1;
    cy = y - 1;
    if (x < 2 || y < 2) return 0;
    if (mode == 3) return pix(pat, cx, cy);
    case (pat)
      // vertical step: |Gx| = 4*200 = 800 -> 255 at centre cols 3,4; Gy = 0
      1, 4:    v = ((mode == 0 || mode == 2) && (cx == 3 || cx == 4)) ? 255 : 0;
      // horizontal step: |Gy| = 4*40 = 160 at centre rows 2,3; Gx = 0
      3:       v = ((mode == 1 || mode == 2) && (cy == 2 || cy == 3)) ? 160 : 0;
      default: v = 0;
    endcase
    if (thr >= 0) v = (v >= thr) ? 255 : 0;
    return v;
  endfunction

  task automatic drive_px(input int pat, input int mode, input int k, input bit frst);
    @(negedge clk);
    iGray      = 8'(pix(pat, k % W, k / W));
    iMODE      = 2'(mode);
    iDVAL      = 1'b1;
    iFRAME_RST = frst;
    in_cyc_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    iDVAL      = 1'b0;
    iFRAME_RST = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input int pat, input int mode, input bit gap, input bit frst);
    for (int k = 0; k < N; k++) begin
      drive_px(pat, mode, k, frst && (k == 0));
      if (gap) begin
        @(negedge clk);
        iDVAL      = 1'b0;
        iFRAME_RST = 1'b0;
      end
    end
    idle(4);
  endtask

  task automatic check_frame(input string tag, input int pat, input int mode, input int thr);
    int n;
    check_val({tag, "_cnt"}, got_q.size(), N);
    n = (got_q.size() < N) ? got_q.size() : N;
    for (int k = 0; k < n; k++) begin
      check_val($sformatf("%s_px%0d", tag, k), got_q[k],
                expect_px(pat, mode, thr, k % W, k / W));
    end
    got_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    iFRAME_RST = 1'b0;
    iGray      = 8'd0;
    iDVAL      = 1'b0;
    iMODE      = 2'd0;
    iTHRESH    = 8'(THR_DEF);
    repeat (3) @(negedge clk);
    check_val("rst_dval", int'(oDVAL), 0);
    check_val("rst_edge", int'(oEdge), 0);
    rst = 1'b0;
    idle(2);

    // Flat frame in every mode
    for (int m = 0; m < 4; m++) begin
      run_frame(0, m, 1'b0, 1'b0);
      check_frame($sformatf("flat_m%0d", m), 0, m, THR_DEF);
    end

    // Reset with two valids in flight
    for (int k = 0; k < 20; k++) drive_px(0, 3, k, 1'b0);
    @(negedge clk);
    iDVAL = 1'b0;
    check_val("pre_rst_dval", int'(oDVAL), 1);
    check_val("pre_rst_edge", int'(oEdge), 100);
    #1 rst = 1'b1;
    #1;
    check_val("async_rst_dval", int'(oDVAL), 0);
    check_val("async_rst_edge", int'(oEdge), 0);
    @(negedge clk);
    check_val("rst_edge_dval", int'(oDVAL), 0);
    check_val("rst_edge_edge", int'(oEdge), 0);
    rst = 1'b0;
    in_cyc_q.delete();
    got_q.delete();
    repeat (10) @(negedge clk);
    check_val("post_rst_pulses", got_q.size(), 0);

    // Vertical steps
    run_frame(1, 0, 1'b0, 1'b0);
    check_frame("vstep_m0", 1, 0, THR_DEF);
    run_frame(1, 1, 1'b0, 1'b0);
    check_frame("vstep_m1", 1, 1, THR_DEF);
    run_frame(1, 2, 1'b0, 1'b0);
    check_frame("vstep_m2", 1, 2, THR_DEF);
    run_frame(4, 0, 1'b0, 1'b0);
    check_frame("vfall_m0", 4, 0, THR_DEF);

    // Ramp passthrough with a gap after every pixel
    run_frame(2, 3, 1'b1, 1'b0);
    check_frame("ramp_gap", 2, 3, THR_DEF);

    // Frame restart coinciding with the first pixel of the next frame
    for (int k = 0; k < 20; k++) drive_px(2, 0, k, 1'b0);
    idle(4);
    got_q.delete();
    run_frame(1, 0, 1'b0, 1'b1);
    check_frame("frst_comb", 1, 0, THR_DEF);

    // Standalone frame restart pulse on an idle cycle
    for (int k = 0; k < 20; k++) drive_px(2, 0, k, 1'b0);
    idle(4);
    got_q.delete();
    iFRAME_RST = 1'b1;
    @(negedge clk);
    iFRAME_RST = 1'b0;
    run_frame(1, 0, 1'b0, 1'b0);
    check_frame("frst_alone", 1, 0, THR_DEF);

    // Horizontal step: vertical gradient
`ifdef EDGE_THRESH_EN
    iTHRESH = 8'd100;
    run_frame(3, 1, 1'b0, 1'b0);
    check_frame("hstep_thr100", 3, 1, 100);
    iTHRESH = 8'd200;
    run_frame(3, 1, 1'b0, 1'b0);
    check_frame("hstep_thr200", 3, 1, 200);
    iTHRESH = 8'(THR_DEF);
    run_frame(3, 3, 1'b0, 1'b0);
    check_frame("hstep_m3_thr", 3, 3, THR_DEF);
`else
    run_frame(3, 1, 1'b0, 1'b0);
    check_frame("hstep_m1", 3, 1, THR_DEF);
    run_frame(3, 2, 1'b0, 1'b0);
    check_frame("hstep_m2", 3, 2, THR_DEF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
    $finish;
  end

endmodule
